serial_subtractor: RTL and testbench

Bit-serial, LSB-first subtractor computing `a - b` over `WIDTH` clock cycles with a single registered borrow. It is the subtract-direction counterpart of the lab's half-adder datapath and is built around a one-bit full-subtractor cell. It sits between operand registers and a consumer that starts it, waits for `done`, and then samples `diff` and `borrow`.

---
 rtl/serial_arith_pkg.sv | 7 +
 rtl/full_subtractor_cell.sv | 17 +
 rtl/serial_subtractor.sv | 88 ++++++++
 tb/tb_serial_subtractor.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: FSM state encoding and default width shared by the serial arithmetic blocks
package serial_arith_pkg;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;
   localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/full_subtractor_cell.sv
// full_subtractor_cell: one-bit full subtractor built from two half-subtractors and an OR
module full_subtractor_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);
   logic w_d1;
   logic w_b1;
   logic w_b2;
   assign w_d1 = a ^ b;
   assign w_b1 = ~a & b;
   assign d    = w_d1 ^ bin;
   assign w_b2 = ~w_d1 & bin;
   assign bout = w_b1 | w_b2;
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first a-b over WIDTH cycles with a registered borrow
// Defining SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int CW = $clog2(WIDTH);
   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow;
   logic [CW-1:0]    r_cnt;
   logic             w_d;
   logic             w_bout;
`ifdef SERIAL_SUB_OVF_EN
   logic             r_a_msb;
   logic             r_b_msb;
   logic             r_ovf;
   assign ovf = r_ovf;
`endif
   full_subtractor_cell u_cell (
      .a   (r_a[0]),
      .b   (r_b[0]),
      .bin (r_borrow),
      .d   (w_d),
      .bout(w_bout)
   );
   assign busy   = r_state != ST_IDLE;
   assign done   = r_state == ST_DONE;
   assign diff   = r_diff;
   assign borrow = r_borrow;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
         r_a_msb  <= 1'b0;
         r_b_msb  <= 1'b0;
         r_ovf    <= 1'b0;
`endif
      end else if (r_state == ST_IDLE && start) begin
         r_state  <= ST_SHIFT;
         r_a      <= a;
         r_b      <= b;
         r_diff   <= '0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
         r_a_msb  <= a[WIDTH-1];
         r_b_msb  <= b[WIDTH-1];
         r_ovf    <= 1'b0;
`endif
      end else if (r_state == ST_SHIFT) begin
         r_a      <= r_a >> 1;
         r_b      <= r_b >> 1;
         r_diff   <= {w_d, r_diff[WIDTH-1:1]};
         r_borrow <= w_bout;
         r_cnt    <= r_cnt + 1'b1;
         r_state  <= (r_cnt == CW'(WIDTH - 1)) ? ST_DONE : ST_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
         // the last processed bit is the result MSB, so overflow settles on the same edge
         if (r_cnt == CW'(WIDTH - 1)) r_ovf <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
`endif
      end else if (r_state == ST_DONE) begin
         r_state  <= ST_IDLE;
      end
   end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor against an arithmetic model
// Honours SERIAL_SUB_OVF_EN to connect and check ovf.
module tb_serial_subtractor;
   localparam int W = 8;
   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif
   int checks = 0;
   int failures = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .borrow(borrow)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] m_diff(input logic [W-1:0] x, input logic [W-1:0] y);
      int unsigned r;
      r = (int'(x) - int'(y) + (1 << W)) % (1 << W);
      return W'(r);
   endfunction

   function automatic logic m_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
      int sd;
      sd = int'($signed(x)) - int'($signed(y));
      return (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
   endfunction

   task automatic chk_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
      chk({tag, "_diff"}, 32'(diff), 32'(m_diff(x, y)));
      chk({tag, "_borrow"}, 32'(borrow), 32'(x < y));
`ifdef SERIAL_SUB_OVF_EN
      chk({tag, "_ovf"}, 32'(ovf), 32'(m_ovf(x, y)));
`endif
   endtask

   // called 1 time unit after a clock edge with the block idle
   task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb);
      int n;
      a = xa;
      b = xb;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      n = 0;
      while (!done && n < 3 * W) begin
         @(posedge clk);
         #1 n++;
      end
      chk("latency", 32'(n), 32'(W));
      chk("busy_at_done", 32'(busy), 32'd1);
      chk_result("op", xa, xb);
      @(posedge clk);
      #1 chk("done_pulse", 32'(done), 32'd0);
      chk("busy_fall", 32'(busy), 32'd0);
      chk_result("hold", xa, xb);
   endtask

   initial begin
      int dcnt;
      logic [W-1:0] ha[0:31];
      logic [W-1:0] hb[0:31];
      logic [W-1:0] sa;
      logic [W-1:0] sb;
      rst = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      repeat (2) @(posedge clk);
      #1 chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_borrow", 32'(borrow), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      chk("rst_ovf", 32'(ovf), 32'd0);
`endif
      rst = 1'b0;
      @(posedge clk);
      #1;
      run_op(8'd200, 8'd55);
      run_op(8'd5, 8'd10);
      run_op(8'd0, 8'd0);
      run_op(8'd255, 8'd0);
      run_op(8'd0, 8'd255);
      run_op(8'h80, 8'h01);
      run_op(8'h10, 8'h01);
      run_op(8'h7F, 8'hFF);
      for (int i = 0; i < 20; i++) run_op(W'($urandom), W'($urandom));

      // start pulses during SHIFT and DONE must be ignored
      sa = W'($urandom);
      sb = W'($urandom);
      a = sa;
      b = sb;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      dcnt = 0;
      for (int i = 1; i <= 15; i++) begin
         if (i == 3 || i == 9) begin
            start = 1'b1;
            a = W'($urandom);
            b = W'($urandom);
         end
         @(posedge clk);
         #1 start = 1'b0;
         if (done) begin
            dcnt++;
            chk("ign_edge", 32'(i), 32'(W));
            chk_result("ign", sa, sb);
         end
      end
      chk("ign_done_count", 32'(dcnt), 32'd1);

      // asynchronous reset in SHIFT cycle 4
      a = 8'd99;
      b = 8'd200;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1 chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_diff", 32'(diff), 32'd0);
      chk("arst_borrow", 32'(borrow), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      chk("arst_ovf", 32'(ovf), 32'd0);
`endif
      @(posedge clk);
      #1 rst = 1'b0;
      dcnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1 if (done) dcnt++;
      end
      chk("arst_no_done", 32'(dcnt), 32'd0);
      run_op(8'd20, 8'd7);

      // start held high: one accept every W+2 edges, each result from its accept edge
      dcnt = 0;
      start = 1'b1;
      for (int k = 0; k < 30; k++) begin
         a = W'($urandom);
         b = W'($urandom);
         ha[k] = a;
         hb[k] = b;
         @(posedge clk);
         #1;
         if (done) begin
            dcnt++;
            chk("held_phase", 32'(k % (W + 2)), 32'(W));
            if (k >= W) chk_result("held", ha[k-W], hb[k-W]);
         end
      end
      start = 1'b0;
      chk("held_done_count", 32'(dcnt), 32'd3);
      repeat (3) @(posedge clk);
      #1 chk("held_idle", 32'(busy), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
